// File: rtl/sensors_scanner.sv
// sensors_scanner: polls four height sensors over a 4-phase req/ack bus and publishes atomic frames
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, cont_mode    one-shot scan request / free-running scan enable
//   bus_sel, bus_req    selected sensor index and request to it
//   bus_ack, bus_data   sensor acknowledge and reading (valid while bus_ack=1)
//   sensor1..sensor4    last committed frame (0 = absent/faulty sensor)
//   frame_valid         one-cycle pulse when sensor1..4 and fault update
//   fault               bit i set when sensor i+1 timed out in the last frame
//   busy                high whenever a scan is in progress
module sensors_scanner #(
    parameter int TIMEOUT = 15,
    parameter int TW      = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       cont_mode,
    output logic [1:0] bus_sel,
    output logic       bus_req,
    input  logic       bus_ack,
    input  logic [7:0] bus_data,
    output logic [7:0] sensor1,
    output logic [7:0] sensor2,
    output logic [7:0] sensor3,
    output logic [7:0] sensor4,
    output logic       frame_valid,
    output logic [3:0] fault,
    output logic       busy
);
    typedef enum logic [1:0] {IDLE, REQ, REL, DONE} state_t;

    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

    state_t        state_q, state_d;
    logic [1:0]    idx_q, idx_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [7:0]    shadow_q [4];
    logic [7:0]    shadow_d [4];
    logic [3:0]    fault_sh_q, fault_sh_d;
    logic [7:0]    sensor_q [4];
    logic [7:0]    sensor_d [4];
    logic [3:0]    fault_q, fault_d;
    logic          frame_valid_q, frame_valid_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            idx_q         <= 2'd0;
            timer_q       <= '0;
            shadow_q      <= '{default: '0};
            fault_sh_q    <= '0;
            sensor_q      <= '{default: '0};
            fault_q       <= '0;
            frame_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            timer_q       <= timer_d;
            shadow_q      <= shadow_d;
            fault_sh_q    <= fault_sh_d;
            sensor_q      <= sensor_d;
            fault_q       <= fault_d;
            frame_valid_q <= frame_valid_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        timer_d       = timer_q;
        shadow_d      = shadow_q;
        fault_sh_d    = fault_sh_q;
        sensor_d      = sensor_q;
        fault_d       = fault_q;
        frame_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start || cont_mode) begin
                    state_d = REQ;
                    idx_d   = 2'd0;
                    timer_d = '0;
                end
            end
            REQ: begin
                // ack wins over a coinciding timeout; a timeout records the absent value 0
                if (bus_ack || timer_q == TMAX) begin
                    shadow_d[idx_q]   = bus_ack ? bus_data : 8'h00;
                    fault_sh_d[idx_q] = !bus_ack;
                    state_d           = REL;
                    timer_d           = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            REL: begin
                // a stuck-high ack flags the sensor but keeps the reading it gave
                if (!bus_ack || timer_q == TMAX) begin
                    if (bus_ack)
                        fault_sh_d[idx_q] = 1'b1;
                    timer_d = '0;
                    if (idx_q == 2'd3) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = REQ;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            DONE: begin
                sensor_d      = shadow_q;
                fault_d       = fault_sh_q;
                frame_valid_d = 1'b1;
                state_d       = cont_mode ? REQ : IDLE;
                idx_d         = 2'd0;
                timer_d       = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    // decoded from the state flop so an asynchronous reset drops the request at once
    assign bus_req     = (state_q == REQ);
    assign bus_sel     = idx_q;
    assign busy        = (state_q != IDLE);
    assign sensor1     = sensor_q[0];
    assign sensor2     = sensor_q[1];
    assign sensor3     = sensor_q[2];
    assign sensor4     = sensor_q[3];
    assign fault       = fault_q;
    assign frame_valid = frame_valid_q;
endmodule
